// File: rtl/tap_pkg.sv
// Shared TAP definitions: 16-state encoding (also the state_obs value) and
// the fixed IR capture pattern.
package tap_pkg;

  typedef enum logic [3:0] {
    ST_TLR      = 4'h0,
    ST_RTI      = 4'h1,
    ST_SEL_IR   = 4'h2,
    ST_CAP_IR   = 4'h3,
    ST_SH_IR    = 4'h4,
    ST_EX1_IR   = 4'h5,
    ST_PAUSE_IR = 4'h6,
    ST_EX2_IR   = 4'h7,
    ST_UPD_IR   = 4'h8,
    ST_SEL_DR   = 4'h9,
    ST_CAP_DR   = 4'hA,
    ST_SH_DR    = 4'hB,
    ST_EX1_DR   = 4'hC,
    ST_PAUSE_DR = 4'hD,
    ST_EX2_DR   = 4'hE,
    ST_UPD_DR   = 4'hF
  } tap_state_e;

  localparam logic [1:0] IR_CAPTURE = 2'b01;

  function automatic logic is_shift_state(input tap_state_e s);
    return (s == ST_SH_IR) || (s == ST_SH_DR);
  endfunction

endpackage

// File: rtl/tap_fsm.sv
// IEEE 1149.1 TAP state machine: TMS-driven next-state logic only.
//   state   | meaning
//   TLR     | test-logic-reset
//   RTI     | run-test/idle
//   SEL_*   | select DR/IR column
//   CAP_*   | capture into shift register
//   SH_*    | shift one bit per clock
//   EX1/2_* | exit states
//   PAUSE_* | hold shift register
//   UPD_*   | update parallel register
module tap_fsm
  import tap_pkg::*;
(
  input  logic       clk,
  input  logic       TRST,
  input  logic       TMS,
  output tap_state_e state
);

  tap_state_e r_state;

  always_ff @(posedge clk) begin
    if (TRST) begin
      r_state <= ST_TLR;
    end else begin
      case (r_state)
        ST_TLR:      r_state <= TMS ? ST_TLR    : ST_RTI;
        ST_RTI:      r_state <= TMS ? ST_SEL_DR : ST_RTI;
        ST_SEL_DR:   r_state <= TMS ? ST_SEL_IR : ST_CAP_DR;
        ST_SEL_IR:   r_state <= TMS ? ST_TLR    : ST_CAP_IR;
        ST_CAP_DR:   r_state <= TMS ? ST_EX1_DR : ST_SH_DR;
        ST_SH_DR:    r_state <= TMS ? ST_EX1_DR : ST_SH_DR;
        ST_EX1_DR:   r_state <= TMS ? ST_UPD_DR : ST_PAUSE_DR;
        ST_PAUSE_DR: r_state <= TMS ? ST_EX2_DR : ST_PAUSE_DR;
        ST_EX2_DR:   r_state <= TMS ? ST_UPD_DR : ST_SH_DR;
        ST_UPD_DR:   r_state <= TMS ? ST_SEL_DR : ST_RTI;
        ST_CAP_IR:   r_state <= TMS ? ST_EX1_IR : ST_SH_IR;
        ST_SH_IR:    r_state <= TMS ? ST_EX1_IR : ST_SH_IR;
        ST_EX1_IR:   r_state <= TMS ? ST_UPD_IR : ST_PAUSE_IR;
        ST_PAUSE_IR: r_state <= TMS ? ST_EX2_IR : ST_PAUSE_IR;
        ST_EX2_IR:   r_state <= TMS ? ST_UPD_IR : ST_SH_IR;
        ST_UPD_IR:   r_state <= TMS ? ST_SEL_DR : ST_RTI;
        default:     r_state <= ST_TLR;
      endcase
    end
  end

  assign state = r_state;

endmodule

// File: rtl/tap_controller.sv
// TAP controller: FSM plus IR, BYPASS and (with TAP_IDCODE_EN) IDCODE
// registers, TDO muxing and user-DR strobes.
module tap_controller
  import tap_pkg::*;
#(
  parameter int unsigned         IR_WIDTH   = 4,
  parameter logic [IR_WIDTH-1:0] BYPASS_OP  = '1,
  parameter logic [IR_WIDTH-1:0] IDCODE_OP  = IR_WIDTH'(1),
  parameter logic [31:0]         IDCODE_VAL = 32'h149511C3
) (
  input  logic                clk,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                tdo_en,
  output logic [3:0]          state_obs,
  output logic [IR_WIDTH-1:0] ir_out,
  output logic                capture_dr,
  output logic                shift_dr,
  output logic                update_dr,
  input  logic                user_tdo
);

`ifdef TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] RESET_INSTR = IDCODE_OP;
`else
  localparam logic [IR_WIDTH-1:0] RESET_INSTR = BYPASS_OP;
`endif

  tap_state_e          w_state;
  logic [IR_WIDTH-1:0] r_ir_sr;
  logic [IR_WIDTH-1:0] r_ir;
  logic [IR_WIDTH-1:0] w_ir_cap;
  logic                r_bypass;
  logic                w_sel_bypass;
  logic                w_sel_idcode;
  logic                w_sel_user;
  logic                w_idcode_tdo;
  logic                w_dr_tdo;

  tap_fsm u_fsm (
    .clk   (clk),
    .TRST  (TRST),
    .TMS   (TMS),
    .state (w_state)
  );

  assign state_obs = w_state;
  assign ir_out    = r_ir;

  always_comb begin
    w_ir_cap      = '0;
    w_ir_cap[1:0] = IR_CAPTURE;
  end

  // Instruction shift register and parallel instruction
  always_ff @(posedge clk) begin
    if (TRST) begin
      r_ir_sr <= '0;
    end else if (w_state == ST_CAP_IR) begin
      r_ir_sr <= w_ir_cap;
    end else if (w_state == ST_SH_IR) begin
      r_ir_sr <= {TDI, r_ir_sr[IR_WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (TRST || (w_state == ST_TLR)) begin
      r_ir <= RESET_INSTR;
    end else if (w_state == ST_UPD_IR) begin
      r_ir <= r_ir_sr;
    end
  end

  assign w_sel_bypass = (r_ir == BYPASS_OP);
  assign w_sel_user   = !w_sel_bypass && !w_sel_idcode;

`ifdef TAP_IDCODE_EN
  logic [31:0] r_idcode;

  assign w_sel_idcode = (r_ir == IDCODE_OP);

  always_ff @(posedge clk) begin
    if (TRST) begin
      r_idcode <= IDCODE_VAL;
    end else if ((w_state == ST_CAP_DR) && w_sel_idcode) begin
      r_idcode <= IDCODE_VAL;
    end else if ((w_state == ST_SH_DR) && w_sel_idcode) begin
      r_idcode <= {TDI, r_idcode[31:1]};
    end
  end

  assign w_idcode_tdo = r_idcode[0];
`else
  logic w_unused_idcode;

  // Without the IDCODE register its opcode decodes as a user instruction
  assign w_sel_idcode    = 1'b0;
  assign w_idcode_tdo    = 1'b0;
  assign w_unused_idcode = ^{IDCODE_OP, IDCODE_VAL};
`endif

  always_ff @(posedge clk) begin
    if (TRST) begin
      r_bypass <= 1'b0;
    end else if ((w_state == ST_CAP_DR) && w_sel_bypass) begin
      r_bypass <= 1'b0;
    end else if ((w_state == ST_SH_DR) && w_sel_bypass) begin
      r_bypass <= TDI;
    end
  end

  assign w_dr_tdo = w_sel_user   ? user_tdo :
                    w_sel_idcode ? w_idcode_tdo : r_bypass;

  always_comb begin
    TDO = 1'b0;
    case (w_state)
      ST_SH_IR: TDO = r_ir_sr[0];
      ST_SH_DR: TDO = w_dr_tdo;
      default:  TDO = 1'b0;
    endcase
  end

  assign tdo_en     = is_shift_state(w_state);
  assign capture_dr = w_sel_user && (w_state == ST_CAP_DR);
  assign shift_dr   = w_sel_user && (w_state == ST_SH_DR);
  assign update_dr  = w_sel_user && (w_state == ST_UPD_DR);

endmodule

// File: tb/tb_tap_controller.sv
// Directed and randomized bench for tap_controller against a queue-based
// reference model; honours TAP_IDCODE_EN.
module tb_tap_controller;

  localparam int IRW = 4;
  localparam int TLR = 0, RTI = 1, SELIR = 2, CAPIR = 3, SHIR = 4, EX1IR = 5,
                 PAUSEIR = 6, EX2IR = 7, UPDIR = 8, SELDR = 9, CAPDR = 10,
                 SHDR = 11, EX1DR = 12, PAUSEDR = 13, EX2DR = 14, UPDDR = 15;
`ifdef TAP_IDCODE_EN
  localparam logic [IRW-1:0] RST_IR = 4'h1;
`else
  localparam logic [IRW-1:0] RST_IR = 4'hF;
`endif

  logic           clk = 1'b0;
  logic           TRST = 1'b0, TMS = 1'b0, TDI = 1'b0, user_tdo = 1'b0;
  logic           TDO, tdo_en, capture_dr, shift_dr, update_dr;
  logic [3:0]     state_obs;
  logic [IRW-1:0] ir_out;

  always #5 clk = ~clk;

  tap_controller #(.IR_WIDTH(IRW)) dut (
    .clk        (clk),
    .TRST       (TRST),
    .TMS        (TMS),
    .TDI        (TDI),
    .TDO        (TDO),
    .tdo_en     (tdo_en),
    .state_obs  (state_obs),
    .ir_out     (ir_out),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .user_tdo   (user_tdo)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Transition table straight from the TMS=0 / TMS=1 rules
  int nxt0[16] = '{RTI, RTI, CAPIR, SHIR, SHIR, PAUSEIR, PAUSEIR, SHIR,
                   RTI, CAPDR, SHDR, SHDR, PAUSEDR, PAUSEDR, SHDR, RTI};
  int nxt1[16] = '{TLR, SELDR, TLR, EX1IR, EX1IR, UPDIR, EX2IR, UPDIR,
                   SELDR, SELIR, EX1DR, EX1DR, UPDDR, EX2DR, UPDDR, SELDR};

  int             m_state;
  logic [IRW-1:0] m_ir;
  bit             ir_q[$];
  bit             dr_q[$];
  logic           last_tdo;
  logic [31:0]    idv = 32'h149511C3;

  function automatic bit is_user(input logic [IRW-1:0] op);
    if (op == 4'hF) return 1'b0;
`ifdef TAP_IDCODE_EN
    if (op == 4'h1) return 1'b0;
`endif
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = TLR;
    m_ir    = RST_IR;
    ir_q.delete();
    for (int i = 0; i < IRW; i++) ir_q.push_back(1'b0);
    dr_q.delete();
    dr_q.push_back(1'b0);
  endtask

  task automatic tick(input logic tms, input logic tdi,
                      input logic utdo = 1'b0, input logic trst = 1'b0);
    bit   usr;
    logic exp_tdo;
    TMS = tms; TDI = tdi; user_tdo = utdo; TRST = trst;
    #1;
    usr     = is_user(m_ir);
    exp_tdo = 1'b0;
    if (m_state == SHIR) exp_tdo = ir_q[0];
    else if (m_state == SHDR) exp_tdo = usr ? utdo : dr_q[0];
    chk("state_obs", state_obs, m_state);
    chk("ir_out", ir_out, m_ir);
    chk("tdo_en", tdo_en, (m_state == SHIR) || (m_state == SHDR));
    chk("TDO", TDO, exp_tdo);
    chk("capture_dr", capture_dr, usr && (m_state == CAPDR));
    chk("shift_dr", shift_dr, usr && (m_state == SHDR));
    chk("update_dr", update_dr, usr && (m_state == UPDDR));
    last_tdo = TDO;
    @(posedge clk);
    if (trst) begin
      model_reset();
    end else begin
      case (m_state)
        TLR: m_ir = RST_IR;
        CAPIR: begin
          ir_q.delete();
          for (int i = 0; i < IRW; i++) ir_q.push_back(i == 0);
        end
        SHIR: begin
          void'(ir_q.pop_front());
          ir_q.push_back(tdi);
        end
        UPDIR: for (int i = 0; i < IRW; i++) m_ir[i] = ir_q[i];
        CAPDR: if (!usr) begin
          dr_q.delete();
          if (m_ir == 4'hF) dr_q.push_back(1'b0);
          else for (int i = 0; i < 32; i++) dr_q.push_back(idv[i]);
        end
        SHDR: if (!usr) begin
          void'(dr_q.pop_front());
          dr_q.push_back(tdi);
        end
        default: ;
      endcase
      m_state = tms ? nxt1[m_state] : nxt0[m_state];
    end
    #1;
  endtask

  task automatic load_ir(input logic [IRW-1:0] op);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < IRW; i++) tick(i == IRW - 1, op[i]);
    tick(1, 0); tick(0, 0);
  endtask

  initial begin
    logic [3:0]  exp_walk[5] = '{4'h1, 4'h9, 4'h2, 4'h3, 4'h4};
    logic [3:0]  walk_tms = 4'b0110;
    logic [3:0]  sh_tdi = 4'b1101;
    logic [3:0]  sh_tdo = 4'b0001;
    logic [2:0]  bp_tdi = 3'b101;
    logic [2:0]  bp_tdo = 3'b010;
    logic [31:0] word;
    logic        u;

    TRST = 1'b1;
    @(posedge clk); #1;
    model_reset();
    tick(0, 0, 0, 1);

    tick(0, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    chk("reach_shdr", state_obs, 4'hB);
    repeat (5) tick(1, 0);
    chk("tms5_state", state_obs, 4'h0);
    chk("tms5_ir", ir_out, RST_IR);

    for (int i = 0; i < 5; i++) begin
      tick(i == 1 || i == 2, 0);
      chk("walk_state", state_obs, exp_walk[i]);
    end
    for (int i = 0; i < 4; i++) begin
      tick(i == 3, sh_tdi[i]);
      chk("ir_shift_tdo", last_tdo, sh_tdo[i]);
    end
    tick(1, 0); tick(0, 0);
    chk("ir_loaded_d", ir_out, 4'hD);
    tick(1, 0); tick(0, 0);
    chk("d_capture", capture_dr, 1'b1);
    tick(0, 0);
    chk("d_shift", shift_dr, 1'b1);
    tick(1, 0); tick(1, 0);
    chk("d_update", update_dr, 1'b1);
    tick(0, 0);

`ifdef TAP_IDCODE_EN
    tick(0, 0, 0, 1);
    tick(0, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    word = '0;
    for (int i = 0; i < 32; i++) begin
      tick(i == 31, 1'($urandom_range(0, 1)));
      word[i] = last_tdo;
    end
    chk("idcode_word", word, 32'h149511C3);
    tick(1, 0); tick(0, 0);
`endif

    load_ir(4'hF);
    chk("ir_bypass", ir_out, 4'hF);
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(i == 2, bp_tdi[i]);
      chk("bypass_tdo", last_tdo, bp_tdo[i]);
    end
    tick(1, 0); tick(0, 0);

    load_ir(4'h5);
    chk("ir_user5", ir_out, 4'h5);
    tick(1, 0); tick(0, 0);
    chk("u5_cap", {capture_dr, shift_dr, update_dr}, 3'b100);
    tick(0, 0);
    chk("u5_shift", {capture_dr, shift_dr, update_dr}, 3'b010);
    for (int i = 0; i < 4; i++) begin
      u = 1'($urandom_range(0, 1));
      tick(i == 3, 1'($urandom_range(0, 1)), u);
      chk("u5_tdo", last_tdo, u);
    end
    tick(1, 0);
    chk("u5_upd", {capture_dr, shift_dr, update_dr}, 3'b001);
    tick(0, 0);
    chk("u5_idle", {capture_dr, shift_dr, update_dr}, 3'b000);

    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    tick(0, 1); tick(0, 0);
    tick(0, 1, 0, 1);
    chk("trst_state", state_obs, 4'h0);
    chk("trst_ir", ir_out, RST_IR);
    chk("trst_tdo_en", tdo_en, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      tick($urandom_range(0, 99) < 40, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom_range(0, 149) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
